ghost_mode_scheduler: RTL and testbench
=======================================

# ghost_mode_scheduler

Generates the per-ghost behaviour schedule that drives the ghost target/steering stage: the one-hot `mode` (chase/scatter/frightened/eaten), the one-tick `rotate` reversal request, and the `update` strobe whose rising edge samples and whose falling edge commits a ghost move. It sits directly upstream of each ghost steering instance and is clocked from the system clock, dividing it down to the game tick.

## Interface
- `TICK_DIV`, 16'd50000: clocks per game tick; even, ≥ 4.
- `SCATTER_TICKS`, 8'd7: ticks per scatter period.
- `CHASE_TICKS`, 8'd20: ticks per chase period.
- `FRIGHT_TICKS`, 8'd6: ticks per frightened period.
- `PHASES`, 4'd4: number of scatter periods before chase becomes permanent.
- `FLASH_TICKS`, 8'd2: final frightened ticks with flashing; only with the macro.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: when low, all counters, state and outputs hold.
- `energizer` in 1: 1-clock pulse; Pac-Man ate a power pellet.
- `ghost_eaten` in 1: 1-clock pulse; Pac-Man collided with this frightened ghost.
- `ghost_home` in 1: level; ghost location equals the ghost-house target.
- `mode` out 4: one-hot, 4'b1000 Chase, 4'b0100 Scatter, 4'b0010 Frightened, 4'b0001 Eaten.
- `rotate` out 1: reverse-direction request for exactly one tick.
- `update` out 1: tick strobe, registered.
- `flash` out 1: frightened-ending indicator; 0 without the macro.

## Operation
- **Divider:** `div_cnt` counts 0..TICK_DIV-1 and wraps. `update` is a flop that is high exactly while `div_cnt` < TICK_DIV/2. An update window is one high phase.
- **Commit edge:** the clock edge where `div_cnt` goes TICK_DIV-2 → TICK_DIV-1. At this edge only, `mode`, `rotate`, `flash`, the timers and the phase counter change. They are therefore stable through the following low phase and the whole next update window.
- **Event latches:** `energizer` and `ghost_eaten` pulses set pending flags at any clock. Flags are evaluated and cleared at the commit edge. `ghost_home` is sampled at the commit edge.
- **State machine:** SCATTER, CHASE, FRIGHT, EATEN. `saved` holds SCATTER or CHASE plus its remaining timer while in FRIGHT or EATEN.
  - SCATTER/CHASE:
    - A pending energizer goes to FRIGHT. Timer loads FRIGHT_TICKS, `rotate`=1, the current timer is frozen in `saved`.
    - Otherwise, timer==1 switches mode: SCATTER→CHASE sets `phase`+1; CHASE→SCATTER happens only if `phase` < PHASES. The new timer loads and `rotate`=1.
    - Otherwise the timer decrements.
    - Once `phase`==PHASES, the CHASE timer does not decrement (chase is permanent).
  - FRIGHT:
    - Pending `ghost_eaten` goes to EATEN with `rotate`=0. It wins over a simultaneous energizer.
    - Otherwise, pending energizer reloads FRIGHT_TICKS.
    - Otherwise, timer==1 returns to `saved` with its frozen timer and `rotate`=0.
    - Otherwise the timer decrements.
  - EATEN: `ghost_home`=1 returns to `saved` with `rotate`=0. Energizer is ignored (its flag is cleared).
- `rotate` clears at the next commit unless that commit sets it again.
- All counters are unsigned and saturating-free. Parameter values of 0 are illegal.

## Timing
- Reset values:
  - `div_cnt`=TICK_DIV-1; `update`=0; `mode`=4'b0100; `rotate`=0; `flash`=0.
  - Timer=SCATTER_TICKS; `phase`=0; event flags 0.
- `update` rises on the first clock edge after reset deasserts. Subsequent rising edges are TICK_DIV clocks apart.
- A mode lasts exactly its tick count in update windows. An event latched during window *n* takes effect in window *n*+1.
- An event arriving after the commit edge of window *n* takes effect in window *n*+2.
- Reset mid-window clears all outputs immediately (asynchronously). Pending events are discarded.

## Configuration
- `GHOST_FLASH_EN` defined: `flash`=1 during the last FLASH_TICKS windows of FRIGHT; it updates at commit and is 0 in all other states.
- `GHOST_FLASH_EN` undefined: `flash` is tied 0 and there is no flash logic.

## Structure
- Shared package `ghost_pkg` holds:
  - Mode encodings: CHASE, SCATTER, FRIGHTENED, EATEN.
  - Direction constants: LEFT 16'h0100, RIGHT 16'hFF00, UP 16'h00FF, DOWN 16'h0001.
  - The state typedef.
- One sub-module, `tick_divider`, owns `div_cnt` and outputs `update` and the one-clock `commit` strobe.

## Test plan
All scenarios use TICK_DIV=4, SCATTER_TICKS=3, CHASE_TICKS=5, FRIGHT_TICKS=2, PHASES=2, FLASH_TICKS=1.
- **Reset and first switch:** release reset → `update` rises at clock 1 and has period 4. Windows 1–3 have `mode`=0100, `rotate`=0. Window 4 has 1000 with `rotate`=1; window 5 has `rotate`=0.
- **Full schedule:** windows 1–3 S, 4–8 C, 9–11 S, 12 onward C. Window 40 is still 1000.
- **Energizer in chase:** energizer pulse in window 5 → windows 6–7 are 0010 (`rotate`=1 in 6 only; with the macro, `flash`=1 in 7). Windows 8–11 are 1000 with `rotate`=0; window 12 is 0100 with `rotate`=1.
- **Eaten and return home:** `ghost_eaten` in window 6 → window 7 is 0001. With `ghost_home`=0 for 10 windows the mode stays 0001. Assert `ghost_home` in window 17 → window 18 returns to 1000 with the saved timer.
- **Simultaneous events:** energizer and `ghost_eaten` in the same clock during FRIGHT → EATEN. An energizer during EATEN leaves it 0001.
- **Mid-window reset:** assert `reset` while `update`=1 → `update`=0, `rotate`=0, `mode`=0100 with no clock edge. After release, the reset-and-first-switch sequence repeats.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared encodings for the ghost blocks: one-hot behaviour modes, steering
// direction vectors and the scheduler state type.
package ghost_pkg;

    localparam logic [3:0] CHASE      = 4'b1000;
    localparam logic [3:0] SCATTER    = 4'b0100;
    localparam logic [3:0] FRIGHTENED = 4'b0010;
    localparam logic [3:0] EATEN      = 4'b0001;

    localparam logic [15:0] LEFT  = 16'h0100;
    localparam logic [15:0] RIGHT = 16'hFF00;
    localparam logic [15:0] UP    = 16'h00FF;
    localparam logic [15:0] DOWN  = 16'h0001;

    typedef enum logic [1:0] {
        ST_SCATTER,
        ST_CHASE,
        ST_FRIGHT,
        ST_EATEN
    } state_t;

    function automatic logic [3:0] mode_of(input state_t s);
        logic [3:0] m;
        m = SCATTER;
        case (s)
            ST_SCATTER: m = SCATTER;
            ST_CHASE:   m = CHASE;
            ST_FRIGHT:  m = FRIGHTENED;
            ST_EATEN:   m = EATEN;
            default:    m = SCATTER;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_tick_divider.sv
// Divides the system clock down to the game tick: update is high for the first
// half of each TICK_DIV period; commit marks the edge that enters the last clock.
module tick_divider #(
    parameter logic [15:0] TICK_DIV = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic update,
    output logic commit
);

    logic [15:0] div_cnt;
    logic [15:0] div_nxt;

    always_comb begin
        div_nxt = (div_cnt == TICK_DIV - 16'd1) ? 16'd0 : div_cnt + 16'd1;
    end

    // Reset parks the count on its last value so the first edge opens window 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= TICK_DIV - 16'd1;
            update  <= 1'b0;
        end else if (enable) begin
            div_cnt <= div_nxt;
            update  <= (div_nxt < (TICK_DIV >> 1));
        end
    end

    assign commit = enable && (div_cnt == TICK_DIV - 16'd2);

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Per-ghost scatter/chase/frightened/eaten schedule with one-tick reversal requests.
// Optional `GHOST_FLASH_EN adds the flash indicator for the end of frightened mode.
module ghost_mode_scheduler
    import ghost_pkg::*;
#(
    parameter logic [15:0] TICK_DIV      = 16'd50000,
    parameter logic [7:0]  SCATTER_TICKS = 8'd7,
    parameter logic [7:0]  CHASE_TICKS   = 8'd20,
    parameter logic [7:0]  FRIGHT_TICKS  = 8'd6,
    parameter logic [3:0]  PHASES        = 4'd4
`ifdef GHOST_FLASH_EN
    ,
    parameter logic [7:0]  FLASH_TICKS   = 8'd2
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       energizer,
    input  logic       ghost_eaten,
    input  logic       ghost_home,
    output logic [3:0] mode,
    output logic       rotate,
    output logic       update,
    output logic       flash
);

    logic   commit;
    state_t state, state_nxt;
    state_t saved_state, saved_state_nxt;
    logic [7:0] timer, timer_nxt;
    logic [7:0] saved_timer, saved_timer_nxt;
    logic [3:0] phase, phase_nxt;
    logic       rotate_nxt;
    logic       ener_pend, eaten_pend;
    logic       ener_evt, eaten_evt;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .update (update),
        .commit (commit)
    );

    // A pulse landing on the commit clock itself is consumed in that commit.
    assign ener_evt  = ener_pend | energizer;
    assign eaten_evt = eaten_pend | ghost_eaten;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_SCATTER;
            timer      <= SCATTER_TICKS;
            phase      <= 4'd0;
            rotate     <= 1'b0;
            ener_pend  <= 1'b0;
            eaten_pend <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            phase  <= phase_nxt;
            rotate <= rotate_nxt;
            if (commit) begin
                ener_pend  <= 1'b0;
                eaten_pend <= 1'b0;
            end else begin
                if (energizer)   ener_pend  <= 1'b1;
                if (ghost_eaten) eaten_pend <= 1'b1;
            end
        end
    end

    // The saved context is only read after FRIGHT/EATEN entry has written it.
    always_ff @(posedge clock) begin
        saved_state <= saved_state_nxt;
        saved_timer <= saved_timer_nxt;
    end

    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        phase_nxt       = phase;
        rotate_nxt      = rotate;
        saved_state_nxt = saved_state;
        saved_timer_nxt = saved_timer;
        if (commit) begin
            rotate_nxt = 1'b0;
            case (state)
                ST_SCATTER, ST_CHASE: begin
                    if (ener_evt) begin
                        state_nxt       = ST_FRIGHT;
                        timer_nxt       = FRIGHT_TICKS;
                        rotate_nxt      = 1'b1;
                        saved_state_nxt = state;
                        saved_timer_nxt = timer;
                    end else if (state == ST_CHASE && phase == PHASES) begin
                        timer_nxt = timer;
                    end else if (timer == 8'd1) begin
                        rotate_nxt = 1'b1;
                        if (state == ST_SCATTER) begin
                            state_nxt = ST_CHASE;
                            timer_nxt = CHASE_TICKS;
                            phase_nxt = phase + 4'd1;
                        end else begin
                            state_nxt = ST_SCATTER;
                            timer_nxt = SCATTER_TICKS;
                        end
                    end else begin
                        timer_nxt = timer - 8'd1;
                    end
                end
                ST_FRIGHT: begin
                    if (eaten_evt) begin
                        state_nxt = ST_EATEN;
                    end else if (ener_evt) begin
                        timer_nxt = FRIGHT_TICKS;
                    end else if (timer == 8'd1) begin
                        state_nxt = saved_state;
                        timer_nxt = saved_timer;
                    end else begin
                        timer_nxt = timer - 8'd1;
                    end
                end
                ST_EATEN: begin
                    if (ghost_home) begin
                        state_nxt = saved_state;
                        timer_nxt = saved_timer;
                    end
                end
                default: begin
                    state_nxt = ST_SCATTER;
                    timer_nxt = SCATTER_TICKS;
                end
            endcase
        end
    end

    always_comb begin
        mode = mode_of(state);
    end

`ifdef GHOST_FLASH_EN
    logic flash_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flash_q <= 1'b0;
        end else if (commit) begin
            flash_q <= (state_nxt == ST_FRIGHT) && (timer_nxt <= FLASH_TICKS);
        end
    end

    assign flash = flash_q;
`else
    assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler using a 4-clock game tick.
module tb_ghost_mode_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       energizer = 1'b0;
    logic       ghost_eaten = 1'b0;
    logic       ghost_home = 1'b0;
    logic [3:0] mode;
    logic       rotate;
    logic       update;
    logic       flash;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_edge = 0;

`ifdef GHOST_FLASH_EN
    localparam logic FLASH_ON = 1'b1;
`else
    localparam logic FLASH_ON = 1'b0;
`endif

    localparam logic [3:0] M_C = 4'b1000;
    localparam logic [3:0] M_S = 4'b0100;
    localparam logic [3:0] M_F = 4'b0010;
    localparam logic [3:0] M_E = 4'b0001;

    ghost_mode_scheduler #(
        .TICK_DIV      (16'd4),
        .SCATTER_TICKS (8'd3),
        .CHASE_TICKS   (8'd5),
        .FRIGHT_TICKS  (8'd2),
        .PHASES        (4'd2)
`ifdef GHOST_FLASH_EN
        ,
        .FLASH_TICKS   (8'd1)
`endif
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .energizer   (energizer),
        .ghost_eaten (ghost_eaten),
        .ghost_home  (ghost_home),
        .mode        (mode),
        .rotate      (rotate),
        .update      (update),
        .flash       (flash)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic start();
        reset       = 1'b1;
        enable      = 1'b1;
        energizer   = 1'b0;
        ghost_eaten = 1'b0;
        ghost_home  = 1'b0;
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        cur_edge = 0;
    endtask

    // Leaves the bench at the falling edge inside update window n.
    task automatic to_window(input int n);
        int target;
        target = 4 * (n - 1) + 1;
        while (cur_edge < target) begin
            @(posedge clock);
            cur_edge++;
        end
        @(negedge clock);
    endtask

    task automatic pulse(input logic e, input logic g);
        energizer   = e;
        ghost_eaten = g;
        @(posedge clock);
        cur_edge++;
        #1;
        energizer   = 1'b0;
        ghost_eaten = 1'b0;
    endtask

    task automatic chk_win(input string s, input int n, input logic [3:0] m, input logic r);
        check($sformatf("%s w%0d update", s, n), {15'd0, update}, 16'd1);
        check($sformatf("%s w%0d mode", s, n), {12'd0, mode}, {12'd0, m});
        check($sformatf("%s w%0d rotate", s, n), {15'd0, rotate}, {15'd0, r});
    endtask

    initial begin
        // Reset state and first switch, enable hold, full schedule.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst mode", {12'd0, mode}, {12'd0, M_S});
        check("rst update", {15'd0, update}, 16'd0);
        check("rst rotate", {15'd0, rotate}, 16'd0);
        check("rst flash", {15'd0, flash}, 16'd0);
        start();
        check("edge0 update", {15'd0, update}, 16'd0);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clock);
            cur_edge++;
            @(negedge clock);
            check($sformatf("edge%0d update", e), {15'd0, update}, (e <= 2) ? 16'd1 : 16'd0);
            check($sformatf("edge%0d mode", e), {12'd0, mode}, {12'd0, M_S});
        end
        to_window(2);
        chk_win("s1", 2, M_S, 1'b0);
        enable = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        check("hold update", {15'd0, update}, 16'd1);
        check("hold mode", {12'd0, mode}, {12'd0, M_S});
        enable = 1'b1;
        to_window(3);  chk_win("s1", 3, M_S, 1'b0);
        to_window(4);  chk_win("s1", 4, M_C, 1'b1);
        to_window(5);  chk_win("s1", 5, M_C, 1'b0);
        to_window(8);  chk_win("s1", 8, M_C, 1'b0);
        to_window(9);  chk_win("s1", 9, M_S, 1'b1);
        to_window(11); chk_win("s1", 11, M_S, 1'b0);
        to_window(12); chk_win("s1", 12, M_C, 1'b1);
        to_window(13); chk_win("s1", 13, M_C, 1'b0);
        to_window(40); chk_win("s1", 40, M_C, 1'b0);

        // Energizer during chase: frighten, then resume the frozen chase timer.
        start();
        to_window(5);  pulse(1'b1, 1'b0);
        to_window(6);  chk_win("s2", 6, M_F, 1'b1);
        check("s2 w6 flash", {15'd0, flash}, 16'd0);
        to_window(7);  chk_win("s2", 7, M_F, 1'b0);
        check("s2 w7 flash", {15'd0, flash}, {15'd0, FLASH_ON});
        to_window(8);  chk_win("s2", 8, M_C, 1'b0);
        check("s2 w8 flash", {15'd0, flash}, 16'd0);
        to_window(11); chk_win("s2", 11, M_C, 1'b0);
        to_window(12); chk_win("s2", 12, M_S, 1'b1);

        // Eaten, energizer ignored while eaten, return home restores saved chase.
        start();
        to_window(5);  pulse(1'b1, 1'b0);
        to_window(6);  pulse(1'b0, 1'b1);
        for (int n = 7; n <= 16; n++) begin
            to_window(n);
            check($sformatf("s3 w%0d mode", n), {12'd0, mode}, {12'd0, M_E});
            if (n == 10) pulse(1'b1, 1'b0);
        end
        to_window(17); check("s3 w17 mode", {12'd0, mode}, {12'd0, M_E});
        ghost_home = 1'b1;
        to_window(18); chk_win("s3", 18, M_C, 1'b0);
        ghost_home = 1'b0;
        to_window(21); chk_win("s3", 21, M_C, 1'b0);
        to_window(22); chk_win("s3", 22, M_S, 1'b1);

        // Simultaneous energizer and eaten while frightened.
        start();
        to_window(5);  pulse(1'b1, 1'b0);
        to_window(6);  pulse(1'b1, 1'b1);
        to_window(7);  chk_win("s4", 7, M_E, 1'b0);

        // Energizer while frightened reloads the fright timer.
        start();
        to_window(5);  pulse(1'b1, 1'b0);
        to_window(7);  pulse(1'b1, 1'b0);
        to_window(8);  chk_win("s5", 8, M_F, 1'b0);
        to_window(9);  chk_win("s5", 9, M_F, 1'b0);
        check("s5 w9 flash", {15'd0, flash}, {15'd0, FLASH_ON});
        to_window(10); chk_win("s5", 10, M_C, 1'b0);
        to_window(13); chk_win("s5", 13, M_C, 1'b0);
        to_window(14); chk_win("s5", 14, M_S, 1'b1);

        // Asynchronous reset in the middle of a window.
        start();
        to_window(4);  chk_win("s6", 4, M_C, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("s6 async update", {15'd0, update}, 16'd0);
        check("s6 async rotate", {15'd0, rotate}, 16'd0);
        check("s6 async mode", {12'd0, mode}, {12'd0, M_S});
        start();
        to_window(1);  chk_win("s6r", 1, M_S, 1'b0);
        to_window(3);  chk_win("s6r", 3, M_S, 1'b0);
        to_window(4);  chk_win("s6r", 4, M_C, 1'b1);
        to_window(5);  chk_win("s6r", 5, M_C, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
